// File: rtl/rec_play_pkg.sv
// ---------------------------------------------------------------------------
// rec_play_pkg
// Shared types and constants for the record/playback controller.
//   state_t  : controller state encoding, visible on o_state
//   KEY_*    : bit positions of each push button inside the key vector
//   cmd_t    : the single command that wins when several keys edge at once
//   pick_cmd : resolves simultaneous key edges into one command
// ---------------------------------------------------------------------------
package rec_play_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_REC        = 3'd2,
        ST_REC_PAUSE  = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5
    } state_t;

    localparam int NUM_KEYS = 6;

    localparam int KEY_STOP = 0;
    localparam int KEY_REC  = 1;
    localparam int KEY_PLAY = 2;
    localparam int KEY_MODE = 3;
    localparam int KEY_UP   = 4;
    localparam int KEY_DOWN = 5;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_STOP = 3'd1,
        CMD_REC  = 3'd2,
        CMD_PLAY = 3'd3,
        CMD_MODE = 3'd4,
        CMD_UP   = 3'd5,
        CMD_DOWN = 3'd6
    } cmd_t;

    // Only the highest-priority edge survives a cycle; the rest are dropped.
    // Order: stop > rec > play > mode > up > down.
    function automatic cmd_t pick_cmd(input logic [NUM_KEYS-1:0] edges);
        cmd_t c;
        c = CMD_NONE;
        if (edges[KEY_STOP])      c = CMD_STOP;
        else if (edges[KEY_REC])  c = CMD_REC;
        else if (edges[KEY_PLAY]) c = CMD_PLAY;
        else if (edges[KEY_MODE]) c = CMD_MODE;
        else if (edges[KEY_UP])   c = CMD_UP;
        else if (edges[KEY_DOWN]) c = CMD_DOWN;
        return c;
    endfunction

endpackage

// File: rtl/key_edge.sv
// ---------------------------------------------------------------------------
// key_edge
// Rising-edge detector over a vector of debounced key levels.
// Ports:
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset (clears key history)
//   i_key  : N debounced key levels
//   o_edge : N flags, 1 while a key is high and was low last clock
// ---------------------------------------------------------------------------
module key_edge
    import rec_play_pkg::*;
#(
    parameter int N = NUM_KEYS
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_key,
    output logic [N-1:0] o_edge
);

    logic [N-1:0] r_key_q;

    // Key history: the previous clock's levels, cleared by reset so a key
    // held through reset is seen as a fresh press afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= i_key;
        end
    end

    assign o_edge = i_key & ~r_key_q;

endmodule

// File: rtl/rec_play_ctrl.sv
// ---------------------------------------------------------------------------
// rec_play_ctrl
// Control FSM for the WM8731 record/playback datapath. Converts key presses
// into one-cycle commands for the recorder and the player, owns the SRAM
// direction select, remembers how much was recorded and tracks the playback
// speed level and interpolation mode.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_init_done           : codec initialiser finished (level)
//   i_key_*               : debounced key levels (rec, play, stop, up, down, mode)
//   i_rec_addr            : recorder write address
//   i_play_addr           : player read address
//   o_state               : current state encoding
//   o_rec_start/pause/stop   : recorder command pulses
//   o_play_start/pause/stop  : player command pulses
//   o_sram_wr             : 1 while the recorder owns the SRAM
//   o_fast, o_slow        : speed direction
//   o_factor              : speed factor 1..MAX_SPEED
//   o_interp              : 1 = linear interpolation in slow play
//   o_rec_len             : end address of the last recording
// ---------------------------------------------------------------------------
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int MAX_SPEED = 8,
    parameter int FACT_W    = $clog2(MAX_SPEED + 1)
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_done,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic              i_key_up,
    input  logic              i_key_down,
    input  logic              i_key_mode,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic [2:0]        o_state,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_sram_wr,
    output logic              o_fast,
    output logic              o_slow,
    output logic [FACT_W-1:0] o_factor,
    output logic              o_interp,
    output logic [ADDR_W-1:0] o_rec_len
);

    // One extra bit over the factor width holds the sign of the speed level.
    localparam int SPD_W = FACT_W + 1;
    localparam logic signed [SPD_W-1:0] SPD_ZERO = '0;
    localparam logic signed [SPD_W-1:0] SPD_ONE  = SPD_W'(1);
    localparam logic signed [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED - 1);
    localparam logic signed [SPD_W-1:0] SPD_MIN  = -SPD_MAX;

    logic [NUM_KEYS-1:0] w_keys;
    logic [NUM_KEYS-1:0] w_edges;
    cmd_t                w_cmd;
    logic                w_full;
    logic                w_eod;
    logic                w_blocked;

    state_t              r_state, w_state_nxt;
    logic                r_rec_start, w_rec_start_nxt;
    logic                r_rec_pause, w_rec_pause_nxt;
    logic                r_rec_stop, w_rec_stop_nxt;
    logic                r_play_start, w_play_start_nxt;
    logic                r_play_pause, w_play_pause_nxt;
    logic                r_play_stop, w_play_stop_nxt;
    logic                r_sram_wr;
    logic [ADDR_W-1:0]   r_rec_len, w_rec_len_nxt;
    logic signed [SPD_W-1:0] r_speed, w_speed_nxt;
    logic                r_interp, w_interp_nxt;
    logic                r_fast, w_fast_nxt;
    logic                r_slow, w_slow_nxt;
    logic [FACT_W-1:0]   r_factor, w_factor_nxt;

    // Gather the key levels into one vector so the edge detector and the
    // priority resolver can work on bit positions from the package.
    always_comb begin
        w_keys           = '0;
        w_keys[KEY_STOP] = i_key_stop;
        w_keys[KEY_REC]  = i_key_rec;
        w_keys[KEY_PLAY] = i_key_play;
        w_keys[KEY_MODE] = i_key_mode;
        w_keys[KEY_UP]   = i_key_up;
        w_keys[KEY_DOWN] = i_key_down;
    end

    key_edge #(.N(NUM_KEYS)) u_key_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_key  (w_keys),
        .o_edge (w_edges)
    );

    // Memory-full while recording and end-of-data while playing are
    // automatic stops; they take the whole cycle, so any key edge that
    // happens together with them is thrown away.
    assign w_full    = (i_rec_addr == {ADDR_W{1'b1}});
    assign w_eod     = (i_play_addr >= r_rec_len);
    assign w_blocked = ((r_state == ST_REC) && w_full) ||
                       ((r_state == ST_PLAY) && w_eod);
    assign w_cmd     = w_blocked ? CMD_NONE : pick_cmd(w_edges);

    // Next-state, command pulses, recorded length, speed level and
    // interpolation mode. Speed and mode keys work in every state except
    // INIT and survive play/stop; only reset clears them.
    always_comb begin
        w_state_nxt      = r_state;
        w_rec_start_nxt  = 1'b0;
        w_rec_pause_nxt  = 1'b0;
        w_rec_stop_nxt   = 1'b0;
        w_play_start_nxt = 1'b0;
        w_play_pause_nxt = 1'b0;
        w_play_stop_nxt  = 1'b0;
        w_rec_len_nxt    = r_rec_len;
        w_speed_nxt      = r_speed;
        w_interp_nxt     = r_interp;

        if (r_state != ST_INIT) begin
            case (w_cmd)
                CMD_MODE: w_interp_nxt = ~r_interp;
                CMD_UP:   if (r_speed < SPD_MAX) w_speed_nxt = r_speed + SPD_ONE;
                CMD_DOWN: if (r_speed > SPD_MIN) w_speed_nxt = r_speed - SPD_ONE;
                default:  ;
            endcase
        end

        case (r_state)
            ST_INIT: begin
                if (i_init_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_cmd == CMD_REC) begin
                    w_state_nxt     = ST_REC;
                    w_rec_start_nxt = 1'b1;
                end else if ((w_cmd == CMD_PLAY) && (r_rec_len != '0)) begin
                    w_state_nxt      = ST_PLAY;
                    w_play_start_nxt = 1'b1;
                end
            end
            ST_REC: begin
                if (w_full) begin
                    w_state_nxt    = ST_IDLE;
                    w_rec_stop_nxt = 1'b1;
                    w_rec_len_nxt  = {ADDR_W{1'b1}};
                end else if (w_cmd == CMD_STOP) begin
                    w_state_nxt    = ST_IDLE;
                    w_rec_stop_nxt = 1'b1;
                    w_rec_len_nxt  = i_rec_addr;
                end else if (w_cmd == CMD_REC) begin
                    w_state_nxt     = ST_REC_PAUSE;
                    w_rec_pause_nxt = 1'b1;
                end
            end
            ST_REC_PAUSE: begin
                if (w_cmd == CMD_STOP) begin
                    w_state_nxt    = ST_IDLE;
                    w_rec_stop_nxt = 1'b1;
                    w_rec_len_nxt  = i_rec_addr;
                end else if (w_cmd == CMD_REC) begin
                    w_state_nxt     = ST_REC;
                    w_rec_start_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_eod || (w_cmd == CMD_STOP)) begin
                    w_state_nxt     = ST_IDLE;
                    w_play_stop_nxt = 1'b1;
                end else if (w_cmd == CMD_PLAY) begin
                    w_state_nxt      = ST_PLAY_PAUSE;
                    w_play_pause_nxt = 1'b1;
                end
            end
            ST_PLAY_PAUSE: begin
                if (w_cmd == CMD_STOP) begin
                    w_state_nxt     = ST_IDLE;
                    w_play_stop_nxt = 1'b1;
                end else if (w_cmd == CMD_PLAY) begin
                    w_state_nxt      = ST_PLAY;
                    w_play_start_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Decode the signed speed level into direction flags and a magnitude
    // factor; level 0 is normal speed with factor 1.
    always_comb begin
        w_fast_nxt   = (w_speed_nxt > SPD_ZERO);
        w_slow_nxt   = (w_speed_nxt < SPD_ZERO);
        w_factor_nxt = w_speed_nxt[SPD_W-1] ? FACT_W'(SPD_ZERO - w_speed_nxt)
                                             : FACT_W'(w_speed_nxt);
        w_factor_nxt = w_factor_nxt + FACT_W'(1);
    end

    // All outputs come from registers; the SRAM select follows the next
    // state so it changes in the same cycle as o_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_rec_start  <= 1'b0;
            r_rec_pause  <= 1'b0;
            r_rec_stop   <= 1'b0;
            r_play_start <= 1'b0;
            r_play_pause <= 1'b0;
            r_play_stop  <= 1'b0;
            r_sram_wr    <= 1'b0;
            r_rec_len    <= '0;
            r_speed      <= SPD_ZERO;
            r_interp     <= 1'b0;
            r_fast       <= 1'b0;
            r_slow       <= 1'b0;
            r_factor     <= FACT_W'(1);
        end else begin
            r_state      <= w_state_nxt;
            r_rec_start  <= w_rec_start_nxt;
            r_rec_pause  <= w_rec_pause_nxt;
            r_rec_stop   <= w_rec_stop_nxt;
            r_play_start <= w_play_start_nxt;
            r_play_pause <= w_play_pause_nxt;
            r_play_stop  <= w_play_stop_nxt;
            r_sram_wr    <= (w_state_nxt == ST_REC);
            r_rec_len    <= w_rec_len_nxt;
            r_speed      <= w_speed_nxt;
            r_interp     <= w_interp_nxt;
            r_fast       <= w_fast_nxt;
            r_slow       <= w_slow_nxt;
            r_factor     <= w_factor_nxt;
        end
    end

    assign o_state      = r_state;
    assign o_rec_start  = r_rec_start;
    assign o_rec_pause  = r_rec_pause;
    assign o_rec_stop   = r_rec_stop;
    assign o_play_start = r_play_start;
    assign o_play_pause = r_play_pause;
    assign o_play_stop  = r_play_stop;
    assign o_sram_wr    = r_sram_wr;
    assign o_fast       = r_fast;
    assign o_slow       = r_slow;
    assign o_factor     = r_factor;
    assign o_interp     = r_interp;
    assign o_rec_len    = r_rec_len;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rec_play_ctrl
// Directed and randomized stimulus for rec_play_ctrl, compared every cycle
// against a behavioural model of the recorder/player controller.
// ---------------------------------------------------------------------------
module tb_rec_play_ctrl;

    localparam int ADDR_W    = 20;
    localparam int MAX_SPEED = 8;
    localparam int FACT_W    = $clog2(MAX_SPEED + 1);
    localparam int FULL_ADDR = (1 << ADDR_W) - 1;

    // Bench key vector bit values.
    localparam logic [5:0] K_REC  = 6'b000001;
    localparam logic [5:0] K_PLAY = 6'b000010;
    localparam logic [5:0] K_STOP = 6'b000100;
    localparam logic [5:0] K_UP   = 6'b001000;
    localparam logic [5:0] K_DOWN = 6'b010000;
    localparam logic [5:0] K_MODE = 6'b100000;

    // Expected pulse vector bits {play_stop,play_pause,play_start,rec_stop,rec_pause,rec_start}.
    localparam logic [5:0] P_REC_START  = 6'b000001;
    localparam logic [5:0] P_REC_PAUSE  = 6'b000010;
    localparam logic [5:0] P_REC_STOP   = 6'b000100;
    localparam logic [5:0] P_PLAY_START = 6'b001000;
    localparam logic [5:0] P_PLAY_PAUSE = 6'b010000;
    localparam logic [5:0] P_PLAY_STOP  = 6'b100000;

    localparam int S_INIT = 0, S_IDLE = 1, S_REC = 2, S_RECP = 3, S_PLAY = 4, S_PLAYP = 5;

    logic              clk;
    logic              rst;
    logic              initDone;
    logic [5:0]        keys;
    logic [ADDR_W-1:0] recAddr;
    logic [ADDR_W-1:0] playAddr;
    logic [2:0]        oState;
    logic              oRecStart, oRecPause, oRecStop;
    logic              oPlayStart, oPlayPause, oPlayStop;
    logic              oSramWr, oFast, oSlow, oInterp;
    logic [FACT_W-1:0] oFactor;
    logic [ADDR_W-1:0] oRecLen;

    rec_play_ctrl #(.ADDR_W(ADDR_W), .MAX_SPEED(MAX_SPEED)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_init_done  (initDone),
        .i_key_rec    (keys[0]),
        .i_key_play   (keys[1]),
        .i_key_stop   (keys[2]),
        .i_key_up     (keys[3]),
        .i_key_down   (keys[4]),
        .i_key_mode   (keys[5]),
        .i_rec_addr   (recAddr),
        .i_play_addr  (playAddr),
        .o_state      (oState),
        .o_rec_start  (oRecStart),
        .o_rec_pause  (oRecPause),
        .o_rec_stop   (oRecStop),
        .o_play_start (oPlayStart),
        .o_play_pause (oPlayPause),
        .o_play_stop  (oPlayStop),
        .o_sram_wr    (oSramWr),
        .o_fast       (oFast),
        .o_slow       (oSlow),
        .o_factor     (oFactor),
        .o_interp     (oInterp),
        .o_rec_len    (oRecLen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values the next applyStimulus drives.
    logic       gRst;
    logic       gInit;
    logic [5:0] gKeys;
    int         gRecAddr;
    int         gPlayAddr;

    // Behavioural model.
    int         mState;
    int         mRecLen;
    int         mSpeed;
    bit         mInterp;
    logic [5:0] mPulse;
    logic [5:0] mPrev;

    int nChecks;
    int nPass;
    int nFail;

    task automatic modelReset();
        mState  = S_INIT;
        mRecLen = 0;
        mSpeed  = 0;
        mInterp = 1'b0;
        mPulse  = '0;
        mPrev   = '0;
    endtask

    // One clock of the controller as described in prose: exactly one
    // surviving key press per cycle, automatic stops override key presses.
    task automatic modelStep();
        logic [5:0] pressed;
        logic [5:0] winner;
        mPulse = '0;
        if (gRst) begin
            modelReset();
        end else begin
            pressed = gKeys & ~mPrev;
            mPrev   = gKeys;
            winner  = '0;
            if (pressed & K_STOP)      winner = K_STOP;
            else if (pressed & K_REC)  winner = K_REC;
            else if (pressed & K_PLAY) winner = K_PLAY;
            else if (pressed & K_MODE) winner = K_MODE;
            else if (pressed & K_UP)   winner = K_UP;
            else if (pressed & K_DOWN) winner = K_DOWN;

            if (mState == S_INIT) begin
                if (gInit) mState = S_IDLE;
            end else if (mState == S_REC && gRecAddr == FULL_ADDR) begin
                mPulse  = P_REC_STOP;
                mState  = S_IDLE;
                mRecLen = FULL_ADDR;
            end else if (mState == S_PLAY && gPlayAddr >= mRecLen) begin
                mPulse = P_PLAY_STOP;
                mState = S_IDLE;
            end else begin
                if (winner == K_MODE) mInterp = ~mInterp;
                if (winner == K_UP   && mSpeed <  MAX_SPEED - 1) mSpeed = mSpeed + 1;
                if (winner == K_DOWN && mSpeed > -(MAX_SPEED - 1)) mSpeed = mSpeed - 1;
                if (winner == K_STOP) begin
                    if (mState == S_REC || mState == S_RECP) begin
                        mPulse = P_REC_STOP; mState = S_IDLE; mRecLen = gRecAddr;
                    end else if (mState == S_PLAY || mState == S_PLAYP) begin
                        mPulse = P_PLAY_STOP; mState = S_IDLE;
                    end
                end else if (winner == K_REC) begin
                    if (mState == S_IDLE || mState == S_RECP) begin
                        mPulse = P_REC_START; mState = S_REC;
                    end else if (mState == S_REC) begin
                        mPulse = P_REC_PAUSE; mState = S_RECP;
                    end
                end else if (winner == K_PLAY) begin
                    if ((mState == S_IDLE && mRecLen != 0) || mState == S_PLAYP) begin
                        mPulse = P_PLAY_START; mState = S_PLAY;
                    end else if (mState == S_PLAY) begin
                        mPulse = P_PLAY_PAUSE; mState = S_PLAYP;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        int absSpeed;
        absSpeed = (mSpeed < 0) ? -mSpeed : mSpeed;
        checkOutput({tag, "/state"}, 32'(oState), 32'(mState));
        checkOutput({tag, "/pulses"},
                    32'({oPlayStop, oPlayPause, oPlayStart, oRecStop, oRecPause, oRecStart}),
                    32'(mPulse));
        checkOutput({tag, "/sram_wr"}, 32'(oSramWr), 32'(mState == S_REC));
        checkOutput({tag, "/fast"}, 32'(oFast), 32'(mSpeed > 0));
        checkOutput({tag, "/slow"}, 32'(oSlow), 32'(mSpeed < 0));
        checkOutput({tag, "/factor"}, 32'(oFactor), 32'(absSpeed + 1));
        checkOutput({tag, "/interp"}, 32'(oInterp), 32'(mInterp));
        checkOutput({tag, "/rec_len"}, 32'(oRecLen), 32'(mRecLen));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model on
    // the rising edge and compare shortly after it.
    task automatic applyStimulus(input logic [5:0] k, input string tag);
        @(negedge clk);
        gKeys    = k;
        rst      = gRst;
        initDone = gInit;
        keys     = gKeys;
        recAddr  = ADDR_W'(gRecAddr);
        playAddr = ADDR_W'(gPlayAddr);
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic press(input logic [5:0] k, input string tag);
        applyStimulus(k, tag);
        applyStimulus(6'b0, {tag, "_rel"});
    endtask

    initial begin
        nChecks   = 0;
        nPass     = 0;
        nFail     = 0;
        gRst      = 1'b1;
        gInit     = 1'b0;
        gKeys     = '0;
        gRecAddr  = 0;
        gPlayAddr = 0;
        rst       = 1'b0;
        initDone  = 1'b0;
        keys      = '0;
        recAddr   = '0;
        playAddr  = '0;
        modelReset();

        #1 rst = 1'b1;
        #1 checkAll("reset");

        // Keys during reset and during INIT are ignored.
        applyStimulus(K_REC | K_UP, "rst_keys");
        applyStimulus(6'b0, "rst_keys2");
        gRst = 1'b0;
        press(K_REC | K_MODE, "init_rec");
        press(K_PLAY, "init_play");
        press(K_UP, "init_up");
        checkOutput("tp_init_hold", 32'(oState), 32'd0);
        gInit = 1'b1;
        applyStimulus(6'b0, "to_idle");
        checkOutput("tp_idle", 32'(oState), 32'd1);

        // Play with nothing recorded does nothing.
        applyStimulus(K_PLAY, "play_empty");
        checkOutput("tp_play_empty_pulse", 32'(oPlayStart), 32'd0);
        checkOutput("tp_play_empty_state", 32'(oState), 32'd1);
        applyStimulus(6'b0, "play_empty_rel");

        // Record then stop at address 0x400.
        applyStimulus(K_REC, "rec");
        checkOutput("tp_rec_start", 32'(oRecStart), 32'd1);
        checkOutput("tp_rec_sram", 32'(oSramWr), 32'd1);
        applyStimulus(6'b0, "rec_rel");
        checkOutput("tp_rec_start_width", 32'(oRecStart), 32'd0);
        gRecAddr = 'h400;
        applyStimulus(K_STOP, "rec_stop");
        checkOutput("tp_rec_stop", 32'(oRecStop), 32'd1);
        checkOutput("tp_rec_len", 32'(oRecLen), 32'h400);
        checkOutput("tp_rec_stop_sram", 32'(oSramWr), 32'd0);
        applyStimulus(6'b0, "rec_stop_rel");

        // Play until the end of the recording.
        gPlayAddr = 0;
        applyStimulus(K_PLAY, "play");
        checkOutput("tp_play_start", 32'(oPlayStart), 32'd1);
        applyStimulus(6'b0, "play_rel");
        gPlayAddr = 'h400;
        applyStimulus(6'b0, "play_eod");
        checkOutput("tp_play_eod", 32'(oPlayStop), 32'd1);
        checkOutput("tp_play_eod_state", 32'(oState), 32'd1);
        gPlayAddr = 0;

        // Speed saturation both ways, then back to normal.
        for (int i = 0; i < 9; i++) press(K_UP, "up");
        checkOutput("tp_fast_sat", 32'(oFast), 32'd1);
        checkOutput("tp_fast_factor", 32'(oFactor), 32'd8);
        for (int i = 0; i < 14; i++) press(K_DOWN, "down");
        checkOutput("tp_slow_sat", 32'(oSlow), 32'd1);
        checkOutput("tp_slow_factor", 32'(oFactor), 32'd8);
        for (int i = 0; i < 7; i++) press(K_UP, "up2");
        checkOutput("tp_norm_fast", 32'(oFast), 32'd0);
        checkOutput("tp_norm_slow", 32'(oSlow), 32'd0);
        checkOutput("tp_norm_factor", 32'(oFactor), 32'd1);
        press(K_MODE, "mode");
        checkOutput("tp_interp", 32'(oInterp), 32'd1);
        press(K_UP, "up3");

        // Memory full wins over a simultaneous rec press.
        press(K_REC, "rec2");
        gRecAddr = FULL_ADDR;
        applyStimulus(K_REC, "rec_full");
        checkOutput("tp_full_stop", 32'(oRecStop), 32'd1);
        checkOutput("tp_full_nopause", 32'(oRecPause), 32'd0);
        checkOutput("tp_full_len", 32'(oRecLen), 32'hFFFFF);
        checkOutput("tp_full_state", 32'(oState), 32'd1);
        gRecAddr = 0;
        applyStimulus(6'b0, "rec_full_rel");

        // Stop beats play in the same cycle.
        press(K_PLAY, "play2");
        applyStimulus(K_STOP | K_PLAY, "stop_play");
        checkOutput("tp_stop_prio", 32'(oPlayStop), 32'd1);
        checkOutput("tp_stop_prio_nopause", 32'(oPlayPause), 32'd0);
        applyStimulus(6'b0, "stop_play_rel");

        // Reset in the middle of PLAY_PAUSE.
        press(K_PLAY, "play3");
        press(K_PLAY, "pause3");
        checkOutput("tp_paused", 32'(oState), 32'd5);
        @(negedge clk);
        #2;
        rst  = 1'b1;
        gRst = 1'b1;
        modelReset();
        #1;
        checkAll("mid_reset");
        checkOutput("tp_mid_reset_state", 32'(oState), 32'd0);
        checkOutput("tp_mid_reset_factor", 32'(oFactor), 32'd1);
        applyStimulus(6'b0, "mid_reset_hold");
        gRst = 1'b0;
        applyStimulus(6'b0, "mid_reset_rel");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            gRecAddr  = ($urandom_range(0, 15) == 0) ? FULL_ADDR : int'($urandom_range(0, 'h3FF));
            gPlayAddr = int'($urandom_range(0, 'h7FF));
            applyStimulus(6'($urandom) & 6'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Parametrised control FSM for the WM8731 record/playback datapath.
- Turns debounced push-button levels into one-cycle command pulses for the recorder and the DSP/player, and drives the SRAM direction select.
- Tracks the recorded length and auto-stops playback at that length.
- Supports a signed speed level (fast/slow up to MAX_SPEED) and a slow-play interpolation mode.

Parameters:
ADDR_W, 20, SRAM word-address width
MAX_SPEED, 8, largest fast/slow factor (>=2)
FACT_W, $clog2(MAX_SPEED+1), width of o_factor

Ports:
i_clk  in  1  system clock (AUD_BCLK domain)
i_rst  in  1  asynchronous active-high reset
i_init_done  in  1  I2C initialiser finished (level)
i_key_rec  in  1  debounced key level, record/pause
i_key_play  in  1  debounced key level, play/pause
i_key_stop  in  1  debounced key level, stop
i_key_up  in  1  debounced key level, speed level +1
i_key_down  in  1  debounced key level, speed level -1
i_key_mode  in  1  debounced key level, toggle interpolation
i_rec_addr  in  ADDR_W  current recorder write address
i_play_addr  in  ADDR_W  current player read address
o_state  out  3  current FSM state encoding
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  recorder command pulses
o_play_start, o_play_pause, o_play_stop  out  1 each  player command pulses
o_sram_wr  out  1  level; 1 = recorder owns SRAM (WE_N low, DQ driven)
o_fast, o_slow  out  1 each  speed direction levels (never both 1)
o_factor  out  FACT_W  speed factor, 1..MAX_SPEED
o_interp  out  1  0 = constant, 1 = linear interpolation
o_rec_len  out  ADDR_W  latched end address of the last recording

Behaviour:
- Reset (i_rst high, async): state INIT; all pulses 0; o_sram_wr 0; o_fast/o_slow 0; o_factor 1; o_interp 0; o_rec_len 0; key history 0.
- Reset asserted mid-operation: immediate return to these values, no stop pulses emitted.
- Key edge: edge = key & ~key_q, with key_q registered each clock.
- All outputs are registered. A command pulse and the state change appear the cycle after the edge-detecting clock.
- Pulses are exactly one cycle wide.
- Edge priority when several occur in one cycle: stop > rec > play > mode > up > down. Lower-priority edges in that cycle are discarded.
- States and transitions:
  - INIT -> IDLE when i_init_done = 1. All keys are ignored in INIT.
  - IDLE:
    - rec -> REC, with rec_start.
    - play -> PLAY, with play_start; only if o_rec_len != 0, otherwise stay in IDLE with no pulse.
  - REC:
    - rec -> REC_PAUSE, with rec_pause.
    - stop -> IDLE, with rec_stop; latch o_rec_len <= i_rec_addr.
    - i_rec_addr == 2^ADDR_W-1 (memory full) -> IDLE, with rec_stop; o_rec_len <= all ones. Full beats a simultaneous key edge.
  - REC_PAUSE:
    - rec -> REC, with rec_start.
    - stop -> IDLE, with rec_stop and the same latch as from REC.
  - PLAY:
    - play -> PLAY_PAUSE, with play_pause.
    - stop -> IDLE, with play_stop.
    - i_play_addr >= o_rec_len -> IDLE, with play_stop. End-of-data beats a simultaneous key edge.
  - PLAY_PAUSE:
    - play -> PLAY, with play_start.
    - stop -> IDLE, with play_stop.
- o_sram_wr = 1 only in REC; 0 in all other states, including REC_PAUSE.
- Speed level: internal signed s in [-(MAX_SPEED-1), +(MAX_SPEED-1)].
  - up: s+1, saturating at the top. down: s-1, saturating at the bottom.
  - Accepted in every state except INIT.
  - s>0: o_fast=1, o_factor=s+1. s<0: o_slow=1, o_factor=-s+1. s=0: both 0, o_factor=1.
  - Outputs update one cycle after the edge.
- mode edge toggles o_interp in any non-INIT state.
- Speed and interp persist across play/stop. Only reset clears them.

Decomposition:
- Package rec_play_pkg:
  - state enum (INIT=0, IDLE=1, REC=2, REC_PAUSE=3, PLAY=4, PLAY_PAUSE=5).
  - key index constants and the priority order.
- Sub-module key_edge #(N=6): registered rising-edge detector over the key vector.

Test Plan:
- Reset held, i_init_done=0, keys toggled -> state stays INIT (0), no pulses; i_init_done=1 -> IDLE (1) next cycle.
- IDLE, rec edge -> rec_start 1 cycle, o_sram_wr=1; i_rec_addr=0x00400, stop edge -> rec_stop 1 cycle, o_rec_len=0x00400, o_sram_wr=0.
- Play from IDLE with o_rec_len=0 -> no play_start, stay IDLE; with o_rec_len=0x00400, play edge -> play_start; i_play_addr=0x00400 -> play_stop, IDLE.
- MAX_SPEED=8, 9 up edges -> o_fast=1, o_factor=8 (saturated); 14 down edges -> o_slow=1, o_factor=8; 7 up edges -> o_fast=o_slow=0, o_factor=1.
- REC with i_rec_addr=0xFFFFF and a simultaneous rec edge -> rec_stop (not rec_pause), o_rec_len=0xFFFFF, IDLE.
- PLAY, stop and play edges in the same cycle -> play_stop only; i_rst pulsed in PLAY_PAUSE -> INIT with all outputs at reset values within the same cycle.
